// File: rtl/traffic_light_sequencer_if.sv
// Mode/button inputs and lamp/status outputs of the traffic light sequencer.
// The sequencer itself uses the slave view; whoever drives sw/btn uses master.
interface traffic_light_sequencer_if;
  logic [1:0] sw;
  logic [3:0] btn;
  logic       light_r;
  logic       light_y;
  logic       light_g;
  logic       ped_walk;
  logic [3:0] remaining;
  logic [1:0] phase;

  modport master (
    output sw, btn,
    input  light_r, light_y, light_g, ped_walk, remaining, phase
  );

  modport slave (
    input  sw, btn,
    output light_r, light_y, light_g, ped_walk, remaining, phase
  );
endinterface

// File: rtl/traffic_light_sequencer.sv
// Traffic light sequencer: RED/GREEN/YELLOW timing on a prescaled tick, with
// pedestrian request, manual stepping, flashing-yellow and off modes.
//
// state     | meaning
// ST_RED    | red lamp; walk lamp on if a request was pending at entry
// ST_GREEN  | green lamp; cut short to T_PED ticks by a pedestrian request
// ST_YELLOW | yellow lamp, then back to red
module traffic_light_sequencer #(
  parameter int CLK_DIV  = 50000000,
  parameter int T_RED    = 5,
  parameter int T_GREEN  = 6,
  parameter int T_YELLOW = 2,
  parameter int T_PED    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  traffic_light_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RED    = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } phase_t;

  localparam logic [1:0] MODE_AUTO   = 2'd1;
  localparam logic [1:0] MODE_MANUAL = 2'd2;
  localparam logic [1:0] MODE_FLASH  = 2'd3;

  localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [3:0]    REM_RED    = 4'(T_RED - 1);
  localparam logic [3:0]    REM_GREEN  = 4'(T_GREEN - 1);
  localparam logic [3:0]    REM_YELLOW = 4'(T_YELLOW - 1);
  localparam logic [3:0]    REM_PED    = 4'(T_PED - 1);

  phase_t        phase_q, phase_n;
  logic [3:0]    rem_q, rem_n;
  logic [PW-1:0] presc_q;
  logic          ped_req_q, ped_req_n;
  logic          walk_q, walk_n;
  logic          flash_q, flash_n;
  logic [3:0]    btn_q;
  logic [1:0]    sw_q;
  logic          lamp_r_q, lamp_y_q, lamp_g_q, ped_walk_q;
  logic          lamp_r_n, lamp_y_n, lamp_g_n, ped_walk_n;
  logic          tick;
  logic          mode_chg;
  logic [3:0]    btn_evt;
  logic          btn_unused;

  assign tick       = (presc_q == PRESC_LAST);
  assign mode_chg   = (bus.sw != sw_q);
  assign btn_evt    = bus.btn & ~btn_q;
  assign btn_unused = ^btn_evt[3:2];

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      ST_RED:   return ST_GREEN;
      ST_GREEN: return ST_YELLOW;
      default:  return ST_RED;
    endcase
  endfunction

  function automatic logic [3:0] reload(input phase_t p);
    case (p)
      ST_GREEN:  return REM_GREEN;
      ST_YELLOW: return REM_YELLOW;
      default:   return REM_RED;
    endcase
  endfunction

  always_comb begin
    phase_n   = phase_q;
    rem_n     = rem_q;
    ped_req_n = ped_req_q;
    walk_n    = walk_q;
    flash_n   = flash_q;

    if (mode_chg) begin
      phase_n   = ST_RED;
      rem_n     = REM_RED;
      ped_req_n = 1'b0;
      walk_n    = 1'b0;
      flash_n   = 1'b0;
    end else if (!(phase_q inside {ST_RED, ST_GREEN, ST_YELLOW})) begin
      phase_n = ST_RED;
      rem_n   = REM_RED;
    end else begin
      case (bus.sw)
        MODE_AUTO: begin
          ped_req_n = ped_req_q | btn_evt[0];
          // A request seen this very cycle already shortens green.
          if (phase_q == ST_GREEN && ped_req_n && rem_q > REM_PED) begin
            rem_n = REM_PED;
          end else if (tick) begin
            if (rem_q != 4'd0) begin
              rem_n = rem_q - 4'd1;
            end else begin
              phase_n = next_phase(phase_q);
              rem_n   = reload(phase_n);
              if (phase_q == ST_RED) walk_n = 1'b0;
              if (phase_n == ST_RED && ped_req_n) begin
                walk_n    = 1'b1;
                ped_req_n = 1'b0;
              end
            end
          end
        end
        MODE_MANUAL: begin
          if (btn_evt[1]) begin
            phase_n = next_phase(phase_q);
            rem_n   = reload(phase_n);
          end
        end
        MODE_FLASH: begin
          if (tick) flash_n = ~flash_q;
        end
        default: ;
      endcase
    end

    // Lamps are registered from the next state so they match phase/remaining.
    lamp_r_n   = 1'b0;
    lamp_y_n   = 1'b0;
    lamp_g_n   = 1'b0;
    ped_walk_n = 1'b0;
    case (bus.sw)
      MODE_AUTO, MODE_MANUAL: begin
        lamp_r_n   = (phase_n == ST_RED);
        lamp_y_n   = (phase_n == ST_YELLOW);
        lamp_g_n   = (phase_n == ST_GREEN);
        ped_walk_n = (bus.sw == MODE_AUTO) & walk_n;
      end
      MODE_FLASH: lamp_y_n = flash_n;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= ST_RED;
      rem_q      <= REM_RED;
      presc_q    <= '0;
      ped_req_q  <= 1'b0;
      walk_q     <= 1'b0;
      flash_q    <= 1'b0;
      btn_q      <= '0;
      sw_q       <= bus.sw;
      lamp_r_q   <= 1'b0;
      lamp_y_q   <= 1'b0;
      lamp_g_q   <= 1'b0;
      ped_walk_q <= 1'b0;
    end else begin
      phase_q    <= phase_n;
      rem_q      <= rem_n;
      presc_q    <= tick ? '0 : presc_q + PW'(1);
      ped_req_q  <= ped_req_n;
      walk_q     <= walk_n;
      flash_q    <= flash_n;
      btn_q      <= bus.btn;
      sw_q       <= bus.sw;
      lamp_r_q   <= lamp_r_n;
      lamp_y_q   <= lamp_y_n;
      lamp_g_q   <= lamp_g_n;
      ped_walk_q <= ped_walk_n;
    end
  end

  assign bus.phase     = phase_q;
  assign bus.remaining = rem_q;
  assign bus.light_r   = lamp_r_q;
  assign bus.light_y   = lamp_y_q;
  assign bus.light_g   = lamp_g_q;
  assign bus.ped_walk  = ped_walk_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Bench for traffic_light_sequencer: directed scenarios with fixed expectations
// plus a randomized run compared against a behavioural model.
module tb_traffic_light_sequencer;
  localparam int CLK_DIV  = 4;
  localparam int T_RED    = 5;
  localparam int T_GREEN  = 6;
  localparam int T_YELLOW = 2;
  localparam int T_PED    = 2;

  logic clk = 1'b0;
  logic rst;

  traffic_light_sequencer_if bus ();

  traffic_light_sequencer #(
    .CLK_DIV (CLK_DIV),
    .T_RED   (T_RED),
    .T_GREEN (T_GREEN),
    .T_YELLOW(T_YELLOW),
    .T_PED   (T_PED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: phases 0/1/2 with durations in ticks, a tick every CLK_DIV clocks.
  int dur[3] = '{T_RED, T_GREEN, T_YELLOW};
  int m_cyc, m_phase, m_rem, m_req, m_walk, m_flash;
  logic [1:0] m_sw_q;
  logic [3:0] m_btn_q;
  logic m_r, m_y, m_g, m_pw;

  function automatic void m_enter(input int p);
    if (m_phase == 0) m_walk = 0;
    m_phase = p;
    m_rem   = dur[p] - 1;
    if (p == 0 && m_req != 0) begin
      m_walk = 1;
      m_req  = 0;
    end
  endfunction

  function automatic void model_clock(input logic r, input logic [1:0] s, input logic [3:0] b);
    bit tk;
    logic [3:0] ev;
    if (r) begin
      m_cyc = 0; m_phase = 0; m_rem = T_RED - 1; m_req = 0; m_walk = 0; m_flash = 0;
      m_btn_q = 4'd0; m_sw_q = s;
      {m_r, m_y, m_g, m_pw} = 4'b0000;
      return;
    end
    tk = ((m_cyc % CLK_DIV) == CLK_DIV - 1);
    m_cyc = m_cyc + 1;
    ev = b & ~m_btn_q;
    m_btn_q = b;
    if (s != m_sw_q) begin
      m_phase = 0; m_rem = T_RED - 1; m_req = 0; m_walk = 0; m_flash = 0;
    end else if (s == 2'd1) begin
      if (ev[0]) m_req = 1;
      if (m_phase == 1 && m_req != 0 && m_rem > T_PED - 1) m_rem = T_PED - 1;
      else if (tk) begin
        if (m_rem > 0) m_rem = m_rem - 1;
        else m_enter((m_phase + 1) % 3);
      end
    end else if (s == 2'd2) begin
      if (ev[1]) m_enter((m_phase + 1) % 3);
    end else if (s == 2'd3) begin
      if (tk) m_flash = 1 - m_flash;
    end
    m_sw_q = s;
    m_r  = (s == 2'd1 || s == 2'd2) && m_phase == 0;
    m_g  = (s == 2'd1 || s == 2'd2) && m_phase == 1;
    m_y  = ((s == 2'd1 || s == 2'd2) && m_phase == 2) || (s == 2'd3 && m_flash == 1);
    m_pw = (s == 2'd1) && m_walk == 1;
  endfunction

  function automatic logic [9:0] dut_vec();
    return {bus.light_r, bus.light_y, bus.light_g, bus.ped_walk, bus.remaining, bus.phase};
  endfunction

  function automatic logic [9:0] mdl_vec();
    return {m_r, m_y, m_g, m_pw, 4'(m_rem), 2'(m_phase)};
  endfunction

  task automatic step();
    @(posedge clk);
    model_clock(rst, bus.sw, bus.btn);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] s);
    rst = 1'b1;
    bus.sw = s;
    bus.btn = 4'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_for(input int p, input int r, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (int'(bus.phase) == p && (r < 0 || int'(bus.remaining) == r)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sw = 2'd1;
    bus.btn = 4'b0011;
    step();
    step();
    vectors++;
    if (dut_vec() !== {4'b0000, 4'd4, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got %b exp %b", dut_vec(), {4'b0000, 4'd4, 2'd0});
    end
    bus.sw = 2'd3;
    bus.btn = 4'd0;
    step();
    vectors++;
    if (dut_vec() !== {4'b0000, 4'd4, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_flash_mode: got %b exp %b", dut_vec(), {4'b0000, 4'd4, 2'd0});
    end
    rst = 1'b0;
  endtask

  task automatic test_auto_cycle();
    int t, eph, erem;
    logic [2:0] elamp;
    do_reset(2'd1);
    for (int k = 0; k < 105; k++) begin
      t = k % 52;
      if (t < 20) begin eph = 0; erem = 4 - t / 4; end
      else if (t < 44) begin eph = 1; erem = 5 - (t - 20) / 4; end
      else begin eph = 2; erem = 1 - (t - 44) / 4; end
      elamp = (k == 0) ? 3'b000 : (eph == 0) ? 3'b100 : (eph == 1) ? 3'b001 : 3'b010;
      vectors++;
      if ({bus.phase, bus.remaining} !== {2'(eph), 4'(erem)}) begin
        miscompares++;
        $display("FAIL auto_cycle k=%0d: phase/rem %0d/%0d exp %0d/%0d", k, bus.phase, bus.remaining, eph, erem);
      end
      vectors++;
      if ({bus.light_r, bus.light_y, bus.light_g, bus.ped_walk} !== {elamp, 1'b0}) begin
        miscompares++;
        $display("FAIL auto_lamps k=%0d: got %b exp %b", k, {bus.light_r, bus.light_y, bus.light_g, bus.ped_walk}, {elamp, 1'b0});
      end
      step();
    end
  endtask

  task automatic test_ped_shorten();
    bit ok;
    int n;
    do_reset(2'd1);
    wait_for(1, 4, 200, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL ped_wait_green4: timeout, got phase %0d", bus.phase); end
    bus.btn = 4'b0001;
    step();
    bus.btn = 4'b0000;
    vectors++;
    if ({bus.phase, bus.remaining} !== {2'd1, 4'd1}) begin
      miscompares++;
      $display("FAIL ped_shorten: phase/rem %0d/%0d exp 1/1", bus.phase, bus.remaining);
    end
    n = 0;
    while (bus.phase == 2'd1 && n < 50) begin step(); n++; end
    vectors++;
    if (n !== 7 || bus.phase !== 2'd2) begin
      miscompares++;
      $display("FAIL ped_green_end: %0d clocks to phase %0d, exp 7 to phase 2", n, bus.phase);
    end
    wait_for(0, -1, 50, ok);
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if ({bus.phase, bus.light_r, bus.ped_walk} !== {2'd0, 1'b1, 1'b1}) begin
        miscompares++;
        $display("FAIL ped_walk_red i=%0d: phase %0d r %b walk %b exp 0 1 1", i, bus.phase, bus.light_r, bus.ped_walk);
      end
      step();
    end
    vectors++;
    if ({bus.phase, bus.ped_walk} !== {2'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL ped_walk_off: phase %0d walk %b exp 1 0", bus.phase, bus.ped_walk);
    end
  endtask

  task automatic test_ped_held();
    bit ok;
    int n, walk_cnt, g;
    wait_for(2, -1, 200, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL held_wait_yellow: timeout, got phase %0d", bus.phase); end
    walk_cnt = 0;
    bus.btn = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.ped_walk) walk_cnt++;
    end
    bus.btn = 4'b0000;
    n = 0;
    while (bus.phase !== 2'd1 && n < 100) begin
      step();
      if (bus.ped_walk) walk_cnt++;
      n++;
    end
    vectors++;
    if (walk_cnt !== 20) begin
      miscompares++;
      $display("FAIL held_walk_count: got %0d exp 20", walk_cnt);
    end
    g = 0;
    while (bus.phase == 2'd1 && g < 100) begin g++; step(); end
    vectors++;
    if (g !== 24) begin
      miscompares++;
      $display("FAIL held_green_len: got %0d exp 24", g);
    end
    wait_for(0, -1, 50, ok);
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if ({bus.phase, bus.ped_walk} !== {2'd0, 1'b0}) begin
        miscompares++;
        $display("FAIL held_second_red i=%0d: phase %0d walk %b exp 0 0", i, bus.phase, bus.ped_walk);
      end
      step();
    end
  endtask

  task automatic test_manual();
    int e;
    logic [2:0] elamp;
    do_reset(2'd2);
    step();
    for (int i = 0; i < 4; i++) begin
      e = i % 3;
      elamp = (e == 0) ? 3'b100 : (e == 1) ? 3'b001 : 3'b010;
      for (int k = 0; k < 100; k++) begin
        vectors++;
        if (dut_vec() !== {elamp, 1'b0, 4'(dur[e] - 1), 2'(e)}) begin
          miscompares++;
          $display("FAIL manual_hold i=%0d k=%0d: got %b exp %b", i, k, dut_vec(), {elamp, 1'b0, 4'(dur[e] - 1), 2'(e)});
        end
        step();
      end
      if (i < 3) begin
        bus.btn = 4'b0010;
        step();
        bus.btn = 4'b0000;
        vectors++;
        if (int'(bus.phase) !== (i + 1) % 3) begin
          miscompares++;
          $display("FAIL manual_step i=%0d: phase %0d exp %0d", i, bus.phase, (i + 1) % 3);
        end
      end
    end
  endtask

  task automatic test_flash();
    int toggles;
    logic prev_y;
    bus.sw = 2'd3;
    step();
    vectors++;
    if (dut_vec() !== {4'b0000, 4'd4, 2'd0}) begin
      miscompares++;
      $display("FAIL flash_enter: got %b exp %b", dut_vec(), {4'b0000, 4'd4, 2'd0});
    end
    toggles = 0;
    prev_y = bus.light_y;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.light_y !== prev_y) toggles++;
      prev_y = bus.light_y;
      vectors++;
      if ({bus.light_r, bus.light_g, bus.ped_walk, bus.phase} !== 5'b00000 || bus.light_y !== m_y) begin
        miscompares++;
        $display("FAIL flash_lamps i=%0d: r%b y%b g%b w%b ph%0d exp y%b", i, bus.light_r, bus.light_y, bus.light_g, bus.ped_walk, bus.phase, m_y);
      end
    end
    vectors++;
    if (toggles !== 10) begin
      miscompares++;
      $display("FAIL flash_toggles: got %0d exp 10", toggles);
    end
    bus.sw = 2'd1;
    step();
    vectors++;
    if (dut_vec() !== {4'b1000, 4'd4, 2'd0}) begin
      miscompares++;
      $display("FAIL flash_to_auto: got %b exp %b", dut_vec(), {4'b1000, 4'd4, 2'd0});
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_for(1, -1, 200, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL mid_wait_green: timeout, got phase %0d", bus.phase); end
    step();
    bus.btn = 4'b0001;
    step();
    bus.btn = 4'b0000;
    step();
    rst = 1'b1;
    step();
    vectors++;
    if (dut_vec() !== {4'b0000, 4'd4, 2'd0}) begin
      miscompares++;
      $display("FAIL mid_reset: got %b exp %b", dut_vec(), {4'b0000, 4'd4, 2'd0});
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      vectors++;
      if ({bus.phase, bus.ped_walk, bus.light_r} !== {2'd0, 1'b0, (k != 0)}) begin
        miscompares++;
        $display("FAIL mid_red k=%0d: phase %0d walk %b r %b", k, bus.phase, bus.ped_walk, bus.light_r);
      end
      step();
    end
    vectors++;
    if ({bus.phase, bus.remaining} !== {2'd1, 4'd5}) begin
      miscompares++;
      $display("FAIL mid_green_full: phase/rem %0d/%0d exp 1/5", bus.phase, bus.remaining);
    end
  endtask

  task automatic test_random();
    int b;
    do_reset(2'($urandom_range(0, 3)));
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) bus.sw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(0, 3);
        bus.btn[b] = ~bus.btn[b];
      end
      rst = ($urandom_range(0, 799) == 0);
      step();
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL random i=%0d sw=%0d btn=%b: got %b exp %b", i, bus.sw, bus.btn, dut_vec(), mdl_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.sw = 2'd1;
    bus.btn = 4'd0;
    test_reset();
    test_auto_cycle();
    test_ped_shorten();
    test_ped_held();
    test_manual();
    test_flash();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog expired");
  end
endmodule
